// File: rtl/alu_share_sched_pkg.sv
// Shared encodings for the execute-stage ALU scheduler: ALU function codes,
// condition-code bit positions and the result-register FSM states.
package alu_share_sched_pkg;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_XOR = 2'd3;

    // Bit positions inside cc = {ZF,SF,OF}
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_share_sched_alu64.sv
// Combinational Y86 OPq ALU: add/sub/and/xor of two W-bit operands plus the
// ZF/SF/OF flags. SUB computes b-a, matching the Y86 operand order.
module alu64_core
    import alu_share_sched_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [1:0]   fun,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         zf,
    output logic         sf,
    output logic         of
);

    logic [W-1:0] sum;
    logic [W-1:0] diff;
    logic [W-1:0] and_r;
    logic [W-1:0] xor_r;

    assign sum   = b + a;
    assign diff  = b - a;
    assign and_r = a & b;
    assign xor_r = a ^ b;

    always_comb begin
        result = sum;
        of     = 1'b0;
        case (fun)
            ALU_ADD: begin
                result = sum;
                of     = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            ALU_SUB: begin
                result = diff;
                of     = (a[W-1] != b[W-1]) && (diff[W-1] != b[W-1]);
            end
            ALU_AND: result = and_r;
            default: result = xor_r;
        endcase
    end

    assign zf = (result == '0);
    assign sf = result[W-1];

endmodule

// File: rtl/alu_share_sched.sv
// Round-robin scheduler sharing one ALU between the OPq path (req0) and the
// address/stack-pointer path (req1); one registered result and the CC register.
module alu_share_sched
    import alu_share_sched_pkg::*;
#(
    parameter int         W        = 64,
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_fun,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_setcc,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_fun,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_result,
    output logic [2:0]   cc,
    output state_t       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // reqN_ready depends combinationally on valid/rsp_ready and is never high
    // without reqN_valid; rsp_* stay stable while rsp_valid && !rsp_ready.

    state_t       state;
    state_t       state_nxt;
    logic         last_grant;
    logic         can_accept;
    logic         grant0;
    logic         grant1;
    logic         accept0;
    logic         accept1;
    logic         accept;
    logic [1:0]   alu_fun;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_result;
    logic         alu_zf;
    logic         alu_sf;
    logic         alu_of;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept)                       state_nxt = ST_FULL;
        else if (state == ST_FULL && rsp_ready) state_nxt = ST_EMPTY;
    end

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        rsp_valid  = (state == ST_FULL);
        can_accept = ((state == ST_EMPTY) || rsp_ready) && !rst;
        grant0     = req0_valid && (!req1_valid || last_grant);
        grant1     = req1_valid && (!req0_valid || !last_grant);
        req0_ready = can_accept && grant0;
        req1_ready = can_accept && grant1;
        dbg_state  = state;
    end

    assign accept0 = req0_valid && req0_ready;
    assign accept1 = req1_valid && req1_ready;
    assign accept  = accept0 || accept1;

    assign alu_fun = accept1 ? req1_fun : req0_fun;
    assign alu_a   = accept1 ? req1_a   : req0_a;
    assign alu_b   = accept1 ? req1_b   : req0_b;

    alu64_core #(.W(W)) u_alu (
        .fun    (alu_fun),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_result),
        .zf     (alu_zf),
        .sf     (alu_sf),
        .of     (alu_of)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_result <= '0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
            cc         <= CC_RESET;
        end else begin
            if (accept) begin
                rsp_result <= alu_result;
                rsp_id     <= accept1;
                last_grant <= accept1;
            end
            if (accept0 && req0_setcc) begin
                cc[CC_ZF] <= alu_zf;
                cc[CC_SF] <= alu_sf;
                cc[CC_OF] <= alu_of;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_sched.sv
// Directed bench for alu_share_sched: reset values, each ALU op and its flags,
// round-robin alternation, backpressure hold, reset out of FULL, setcc gating.
module tb_alu_share_sched;
    import alu_share_sched_pkg::*;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid;
    logic         req0_ready;
    logic [1:0]   req0_fun;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_setcc;
    logic         req1_valid;
    logic         req1_ready;
    logic [1:0]   req1_fun;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_result;
    logic [2:0]   cc;
    state_t       dbg_state;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] id_q[$];

    alu_share_sched #(.W(W), .CC_RESET(3'b100)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_fun   (req0_fun),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_setcc (req0_setcc),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_fun   (req1_fun),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .cc         (cc),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_fun = ALU_ADD; req0_a = '0; req0_b = '0; req0_setcc = 1'b0;
        req1_valid = 1'b0; req1_fun = ALU_ADD; req1_a = '0; req1_b = '0;
    endtask

    // driver: single req0 operation accepted at the next edge
    task automatic issue0(input logic [1:0] fun, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic setcc);
        req0_valid = 1'b1; req0_fun = fun; req0_a = a; req0_b = b; req0_setcc = setcc;
        req1_valid = 1'b0;
        #1;
        check("req0_ready_single", 64'(req0_ready), 64'd1);
        tick();
        req0_valid = 1'b0;
    endtask

    task automatic issue1(input logic [1:0] fun, input logic [W-1:0] a, input logic [W-1:0] b);
        req1_valid = 1'b1; req1_fun = fun; req1_a = a; req1_b = b;
        req0_valid = 1'b0;
        #1;
        check("req1_ready_single", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic exp_grant;

    initial begin
        idle_inputs();
        rsp_ready = 1'b1;
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick();
        check("rst_ready0", 64'(req0_ready), 64'd0);
        check("rst_ready1", 64'(req1_ready), 64'd0);
        tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        check("reset_cc", 64'(cc), 64'h4);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_result", rsp_result, 64'd0);
        check("idle_ready0", 64'(req0_ready), 64'd0);

        // AND with negative operand
        issue0(ALU_AND, 64'd1092835, -64'sd1020, 1'b1);
        check("and_valid", 64'(rsp_valid), 64'd1);
        check("and_id", 64'(rsp_id), 64'd0);
        check("and_result", rsp_result, 64'd1092608);
        check("and_cc", 64'(cc), 64'h0);

        // signed overflow on ADD
        issue0(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        check("add_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFE);
        check("add_cc", 64'(cc), 64'h3);
        issue1(ALU_SUB, 64'd5, 64'd5);
        check("req1_sub_result", rsp_result, 64'd0);
        check("req1_sub_id", 64'(rsp_id), 64'd1);
        check("req1_cc_kept", 64'(cc), 64'h3);

        // round robin, both valid every cycle
        do_reset();
        exp_grant = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req0_valid = 1'b1; req0_fun = ALU_ADD; req0_a = 64'(i); req0_b = 64'd100; req0_setcc = 1'b0;
            req1_valid = 1'b1; req1_fun = ALU_XOR; req1_a = 64'(i); req1_b = 64'hFF;
            #1;
            check("rr_ready0", 64'(req0_ready), 64'(!exp_grant));
            check("rr_ready1", 64'(req1_ready), 64'(exp_grant));
            id_q.push_back(64'(exp_grant));
            exp_q.push_back(exp_grant ? (64'(i) ^ 64'hFF) : (64'd100 + 64'(i)));
            tick();
            check("rr_valid", 64'(rsp_valid), 64'd1);
            check("rr_id", 64'(rsp_id), id_q.pop_front());
            check("rr_result", rsp_result, exp_q.pop_front());
            exp_grant = !exp_grant;
        end
        idle_inputs();

        // backpressure hold
        issue0(ALU_XOR, 64'hF0, 64'hFF, 1'b0);
        check("xor_result", rsp_result, 64'h0F);
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_fun = ALU_ADD; req0_a = 64'd7; req0_b = 64'd9;
        req1_valid = 1'b1; req1_fun = ALU_ADD; req1_a = 64'd2; req1_b = 64'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_ready0", 64'(req0_ready), 64'd0);
            check("hold_ready1", 64'(req1_ready), 64'd0);
            tick();
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_result", rsp_result, 64'h0F);
            check("hold_id", 64'(rsp_id), 64'd0);
        end
        check("hold_state", 64'(dbg_state), 64'(ST_FULL));
        rsp_ready = 1'b1;
        #1;
        check("release_ready1", 64'(req1_ready), 64'd1);
        check("release_ready0", 64'(req0_ready), 64'd0);
        tick();
        check("release_id", 64'(rsp_id), 64'd1);
        check("release_result", rsp_result, 64'd5);
        idle_inputs();
        tick();
        check("drain_valid", 64'(rsp_valid), 64'd0);

        // reset while FULL
        issue0(ALU_SUB, 64'd3, 64'd1, 1'b1);
        check("sub_cc", 64'(cc), 64'h2);
        check("sub_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFE);
        rsp_ready = 1'b0;
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rst_full_ready0", 64'(req0_ready), 64'd0);
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        idle_inputs();
        check("rst_full_valid", 64'(rsp_valid), 64'd0);
        check("rst_full_result", rsp_result, 64'd0);
        check("rst_full_cc", 64'(cc), 64'h4);
        req0_valid = 1'b1; req0_fun = ALU_SUB; req0_a = 64'd3; req0_b = 64'd1; req0_setcc = 1'b1;
        req1_valid = 1'b1; req1_fun = ALU_AND; req1_a = 64'd6; req1_b = 64'd3;
        #1;
        check("tie_ready0", 64'(req0_ready), 64'd1);
        check("tie_ready1", 64'(req1_ready), 64'd0);
        tick();
        check("tie_id", 64'(rsp_id), 64'd0);
        check("tie_cc", 64'(cc), 64'h2);
        idle_inputs();

        // setcc gating
        issue0(ALU_SUB, 64'd1, 64'd1, 1'b0);
        check("nosetcc_result", rsp_result, 64'd0);
        check("nosetcc_cc", 64'(cc), 64'h2);
        issue0(ALU_SUB, 64'd1, 64'd1, 1'b1);
        check("setcc_cc", 64'(cc), 64'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_share_sched.md
Name: alu_share_sched

Overview:
- Schedules the single 64-bit Y86 execute-stage ALU (add/sub/and/xor) between two requesters.
  - Requester 0: the execute-stage OPq path, which may update condition codes.
  - Requester 1: the address/stack-pointer arithmetic path, which never updates condition codes.
- Round-robin valid/ready arbitration, a registered result with one-cycle latency, and a response channel with backpressure.
- Owns the CC register {ZF,SF,OF} consumed by cmov/jXX logic.

Parameters:
- W, 64, operand/result width.
- CC_RESET, 3'b100, reset value of {ZF,SF,OF}; ZF=1 per Y86 convention.

Ports:
- clk  in  1  clock; everything samples on posedge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_fun  in  2  0 ADD, 1 SUB, 2 AND, 3 XOR.
- req0_a  in  W  operand valA.
- req0_b  in  W  operand valB.
- req0_setcc  in  1  update CC with this operation's flags.
- req1_valid  in  1  requester 1 has an operation.
- req1_ready  out  1  requester 1 operation accepted this cycle.
- req1_fun  in  2  same encoding as req0_fun.
- req1_a  in  W  operand.
- req1_b  in  W  operand.
- rsp_valid  out  1  result register holds an unconsumed result.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  requester that issued the held result.
- rsp_result  out  W  result.
- cc  out  3  {ZF,SF,OF}.

Behaviour:
- Function encoding, matching Y86 OPq:
  - ADD = b+a.
  - SUB = b−a.
  - AND = a&b.
  - XOR = a^b.
  - All results are modulo 2^W.
- Flags:
  - ZF = (result==0); SF = result[W-1].
  - OF for ADD: a,b same sign and result sign differs.
  - OF for SUB: a,b signs differ and result sign differs from b.
  - OF = 0 for AND/XOR.
- FSM has two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_accept = (state==EMPTY) | rsp_ready.
- Grant:
  - Only one valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - reqN_ready = can_accept & grantN. Ready is combinational and never asserted without valid.
- Accept (valid&ready at edge N):
  - rsp_result, rsp_id and last_grant are loaded at edge N.
  - State becomes FULL; rsp_valid is high in cycle N+1. Latency is 1 cycle.
- Back-to-back: in FULL with rsp_ready=1 and a valid request, the new result replaces the old at the same edge, giving 1 op/cycle throughput.
- FULL, rsp_ready=1, no request: state returns to EMPTY.
- FULL, rsp_ready=0:
  - rsp_* are held stable.
  - Both ready outputs are 0; requester inputs are ignored.
- CC update:
  - Only on an accept of requester 0 with req0_setcc=1; CC is loaded at the accept edge.
  - Requester 1 accepts and setcc=0 accepts leave CC unchanged.
  - CC reflects the new flags from cycle N+1, coincident with rsp_valid.
- Reset (synchronous, any state, including FULL):
  - rsp_valid=0, rsp_id=0, rsp_result=0, cc=CC_RESET, last_grant=1. Requester 0 wins the first tie.
  - The held result is discarded.
  - Both ready outputs are 0 while rst=1, regardless of valid.
- No X propagation: operands are captured only on accept.

Decomposition:
- Shared package/header holds:
  - ALU function codes (ALU_ADD=2'd0, ALU_SUB=2'd1, ALU_AND=2'd2, ALU_XOR=2'd3).
  - CC bit indices (CC_ZF=2, CC_SF=1, CC_OF=0).
  - FSM state encodings (ST_EMPTY, ST_FULL).
- One combinational sub-module, alu64_core: inputs fun, a, b; outputs result, zf, sf, of.
  - Built from the existing 64-bit and/add/sub/xor units, selected by fun.
- The scheduler holds only the FSM, arbiter, result register and CC register.

Test Plan:
- After reset, check cc=3'b100 and rsp_valid=0. Then req0 AND, a=64'd1092835, b=-64'd1020, setcc=1, rsp_ready=1 → next cycle rsp_valid=1, rsp_id=0, rsp_result=64'd1092608, cc=3'b000.
- req0 ADD, a=b=64'h7FFF_FFFF_FFFF_FFFF, setcc=1 → rsp_result=64'hFFFF_FFFF_FFFF_FFFE, cc=3'b011. Then req1 SUB, a=b=5 → rsp_result=0, cc unchanged at 3'b011.
- Both requesters valid continuously after reset, rsp_ready=1 → accepts alternate 0,1,0,1. Each rsp_id matches 1 cycle later; throughput is 1 op/cycle.
- Accept req0 XOR, a=64'hF0, b=64'hFF, then hold rsp_ready=0 for 3 cycles with both requesters valid → rsp_result=64'h0F stays stable, both ready=0. When rsp_ready rises, a new accept happens the same cycle.
- With rsp_valid=1 and cc updated to 3'b010 (req0 SUB, a=3, b=1, setcc=1), assert rst for 1 cycle → rsp_valid=0, rsp_result=0, cc=3'b100. The next tie grants requester 0.
- req0 SUB, a=1, b=1, setcc=0 → rsp_result=0, cc unchanged. Repeat with setcc=1 → cc=3'b100.
